dvfs_governor: RTL and testbench
================================

Name: dvfs_governor

Overview:
- Consumer of the utilization metric produced by the performance counter.
- Applies hysteresis to 0–100 % utilization samples and selects one of NUM_LEVELS operating points.
- Sequences each change through voltage-regulator and PLL request/acknowledge handshakes.
  - Up-steps raise voltage before frequency.
  - Down-steps lower frequency before voltage.

Parameters:
- NUM_LEVELS, 4, number of operating points (level 0 = lowest V/F).
- LVL_W, 2, width of level fields; must satisfy 2**LVL_W >= NUM_LEVELS.
- UP_THRESH, 80, utilization % at or above which a sample votes up.
- DOWN_THRESH, 30, utilization % at or below which a sample votes down; must be < UP_THRESH.
- HYST_SAMPLES, 3, consecutive same-direction votes required to start a step (1..15).
- ACK_TIMEOUT, 255, cycles to wait for an ack before aborting (8-bit counter).
- RESET_LEVEL, 0, operating point after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- util_valid  in  1  one-cycle strobe; util_percent holds a new sample
- util_percent  in  16  utilization %, values >100 saturate to 100
- volt_req  out  1  voltage change request, held until volt_ack
- volt_level  out  LVL_W  target voltage level, stable while volt_req=1
- volt_ack  in  1  regulator acknowledge (level or pulse)
- freq_req  out  1  frequency change request, held until freq_ack
- freq_level  out  LVL_W  target frequency level, stable while freq_req=1
- freq_ack  in  1  PLL acknowledge
- op_level  out  LVL_W  committed operating point
- busy  out  1  high whenever FSM is not IDLE
- timeout_err  out  1  sticky; set on ack timeout, cleared only by rst

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FSM→IDLE.
  - op_level, volt_level, freq_level = RESET_LEVEL.
  - volt_req, freq_req, busy, timeout_err = 0.
  - Vote counters and timeout counter = 0.
  - rst mid-sequence drops requests the next cycle with no ack required.
- Voting (IDLE only), per util_valid sample u (saturated):
  - u ≥ UP_THRESH and op_level < NUM_LEVELS-1: up_cnt++, down_cnt=0.
  - u ≤ DOWN_THRESH and op_level > 0: down_cnt++, up_cnt=0.
  - Otherwise, including saturated at limit: both counters cleared.
  - util_valid outside IDLE is ignored; both counters are held at 0.
- Trigger:
  - The posedge that samples the vote making up_cnt==HYST_SAMPLES moves IDLE→V_UP and clears counters.
  - volt_req=1 and volt_level=op_level+1 are visible the cycle after that vote.
  - down_cnt reaching HYST_SAMPLES moves IDLE→F_DOWN the same way, with freq_req=1 and freq_level=op_level-1.
  - Exactly one level per step.
- FSM transitions:
  - IDLE → V_UP / F_DOWN as above.
  - V_UP: on volt_ack=1 → F_UP; volt_req=0 and freq_req=1 (freq_level=op_level+1) on the next cycle.
  - F_UP: on freq_ack=1 → IDLE; op_level+=1 and freq_req=0 on the next cycle.
  - F_DOWN: on freq_ack=1 → V_DOWN; freq_req=0 and volt_req=1 (volt_level=op_level-1).
  - V_DOWN: on volt_ack=1 → IDLE; op_level-=1 and volt_req=0.
- Acks are sampled only in the state expecting them. Acks in other states, and both acks high together, are ignored except for the expected one.
- Timeout:
  - The counter resets on entering each request state and increments each cycle without the expected ack.
  - When it reaches ACK_TIMEOUT: drop the request, set timeout_err, go to IDLE. op_level is unchanged.
  - volt_level/freq_level keep their last driven value.
- busy deasserts in the same cycle op_level updates.

Optional Feature:
- Macro: DVFS_GOV_OVERRIDE_EN.
- Defined: adds inputs force_en (1) and force_level (LVL_W).
  - While force_en=1 in IDLE and force_level≠op_level (clamped to NUM_LEVELS-1), a step toward force_level starts immediately with no voting. Stepping repeats until equal.
  - Votes are ignored and counters held at 0 while force_en=1.
  - force_en changes during a sequence take effect only on return to IDLE.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset to level 0. Three samples u=90 with acks returned 2 cycles after each req → volt_req(volt_level=1), then freq_req(freq_level=1), then op_level=1, busy=0, timeout_err=0.
- Level 2. Samples 10, 10, 50, 10, 10 → no request (counter cleared by 50). Third consecutive 10 → freq_req first with freq_level=1, then volt_req volt_level=1, op_level=1.
- Level 3 (max). Five samples u=100; then u=250 → no request, op_level stays 3. At level 0 with u=0 ×5 → no request.
- Up-step with volt_ack never asserted → volt_req drops after 255 cycles, timeout_err=1 (sticky through later samples), op_level unchanged, subsequent steps still operate.
- Samples u=95 arriving while busy during an up-step → ignored. After the step completes, two more u=95 samples do not trigger; the third does.
- rst asserted while freq_req=1 in F_UP → next cycle freq_req=0, op_level=RESET_LEVEL, busy=0. With DVFS_GOV_OVERRIDE_EN: force_en=1, force_level=3 from level 0 → three back-to-back sequences, op_level=3.

Source files
------------

// File: rtl/dvfs_governor.sv
// DVFS governor: hysteresis voting on utilization samples, then one-level V/F steps sequenced
// through regulator/PLL handshakes. Optional DVFS_GOV_OVERRIDE_EN adds a forced-target override.
module dvfs_governor #(
  parameter int NUM_LEVELS   = 4,
  parameter int LVL_W        = 2,
  parameter int UP_THRESH    = 80,
  parameter int DOWN_THRESH  = 30,
  parameter int HYST_SAMPLES = 3,
  parameter int ACK_TIMEOUT  = 255,
  parameter int RESET_LEVEL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             util_valid,
  input  logic [15:0]      util_percent,
  output logic             volt_req,
  output logic [LVL_W-1:0] volt_level,
  input  logic             volt_ack,
  output logic             freq_req,
  output logic [LVL_W-1:0] freq_level,
  input  logic             freq_ack,
  output logic [LVL_W-1:0] op_level,
  output logic             busy,
  output logic             timeout_err
`ifdef DVFS_GOV_OVERRIDE_EN
  ,
  input  logic             force_en,
  input  logic [LVL_W-1:0] force_level
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_V_UP, S_F_UP, S_F_DOWN, S_V_DOWN} state_t;

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] ONE_LVL = LVL_W'(1);
  localparam logic [3:0]       HYST    = 4'(HYST_SAMPLES);
  localparam logic [7:0]       TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [LVL_W-1:0] op_q, op_d, vl_q, vl_d, fl_q, fl_d;
  logic [3:0]       up_q, up_d, down_q, down_d;
  logic [7:0]       to_q, to_d;
  logic             terr_q, terr_d;
  logic [6:0]       u_sat;
  logic             up_vote, down_vote, start_up, start_down;

  assign u_sat     = (util_percent > 16'd100) ? 7'd100 : util_percent[6:0];
  assign up_vote   = (u_sat >= 7'(UP_THRESH))   && (op_q < MAX_LVL);
  assign down_vote = (u_sat <= 7'(DOWN_THRESH)) && (op_q != '0);

`ifdef DVFS_GOV_OVERRIDE_EN
  logic [LVL_W-1:0] force_tgt;
  assign force_tgt = (force_level > MAX_LVL) ? MAX_LVL : force_level;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    vl_d       = vl_q;
    fl_d       = fl_q;
    up_d       = '0;
    down_d     = '0;
    to_d       = to_q + 8'd1;
    terr_d     = terr_q;
    start_up   = 1'b0;
    start_down = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        to_d   = '0;
        up_d   = up_q;
        down_d = down_q;
`ifdef DVFS_GOV_OVERRIDE_EN
        if (force_en) begin
          up_d       = '0;
          down_d     = '0;
          start_up   = force_tgt > op_q;
          start_down = force_tgt < op_q;
        end else
`endif
        if (util_valid) begin
          if (up_vote) begin
            up_d     = up_q + 4'd1;
            down_d   = '0;
            start_up = (up_q + 4'd1) == HYST;
          end else if (down_vote) begin
            down_d     = down_q + 4'd1;
            up_d       = '0;
            start_down = (down_q + 4'd1) == HYST;
          end else begin
            up_d   = '0;
            down_d = '0;
          end
        end
        if (start_up) begin
          state_d = S_V_UP;
          vl_d    = op_q + ONE_LVL;
          up_d    = '0;
          down_d  = '0;
        end else if (start_down) begin
          state_d = S_F_DOWN;
          fl_d    = op_q - ONE_LVL;
          up_d    = '0;
          down_d  = '0;
        end
      end
      S_V_UP: begin
        if (volt_ack) begin
          state_d = S_F_UP;
          fl_d    = op_q + ONE_LVL;
          to_d    = '0;
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end
      end
      S_F_UP: begin
        if (freq_ack) begin
          state_d = S_IDLE;
          op_d    = op_q + ONE_LVL;
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end
      end
      S_F_DOWN: begin
        if (freq_ack) begin
          state_d = S_V_DOWN;
          vl_d    = op_q - ONE_LVL;
          to_d    = '0;
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end
      end
      S_V_DOWN: begin
        if (volt_ack) begin
          state_d = S_IDLE;
          op_d    = op_q - ONE_LVL;
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= LVL_W'(RESET_LEVEL);
      vl_q    <= LVL_W'(RESET_LEVEL);
      fl_q    <= LVL_W'(RESET_LEVEL);
      up_q    <= '0;
      down_q  <= '0;
      to_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vl_q    <= vl_d;
      fl_q    <= fl_d;
      up_q    <= up_d;
      down_q  <= down_d;
      to_q    <= to_d;
      terr_q  <= terr_d;
    end
  end

  // Requests decode straight from state so an abort or reset drops them on the same edge.
  assign volt_req    = (state_q == S_V_UP) || (state_q == S_V_DOWN);
  assign freq_req    = (state_q == S_F_UP) || (state_q == S_F_DOWN);
  assign busy        = state_q != S_IDLE;
  assign volt_level  = vl_q;
  assign freq_level  = fl_q;
  assign op_level    = op_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_dvfs_governor.sv
// Directed, table-driven bench for dvfs_governor: voting table plus hand-written handshake,
// timeout, reset and (with DVFS_GOV_OVERRIDE_EN) override sequences.
module tb_dvfs_governor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        util_valid = 1'b0;
  logic [15:0] util_percent = '0;
  logic        volt_req, freq_req, busy, timeout_err;
  logic [1:0]  volt_level, freq_level, op_level;
  logic        volt_ack = 1'b0;
  logic        freq_ack = 1'b0;
  logic        force_en = 1'b0;
  logic [1:0]  force_level = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dvfs_governor dut (
    .clk         (clk),
    .rst         (rst),
    .util_valid  (util_valid),
    .util_percent(util_percent),
    .volt_req    (volt_req),
    .volt_level  (volt_level),
    .volt_ack    (volt_ack),
    .freq_req    (freq_req),
    .freq_level  (freq_level),
    .freq_ack    (freq_ack),
    .op_level    (op_level),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef DVFS_GOV_OVERRIDE_EN
    ,
    .force_en    (force_en),
    .force_level (force_level)
`endif
  );

  typedef struct {
    int u;
    bit exp_vreq;
    bit exp_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int u);
    util_percent = 16'(u);
    util_valid   = 1'b1;
    step();
    util_valid   = 1'b0;
  endtask

  task automatic wait_req(input bit is_volt, input string name);
    for (int i = 0; i < 20; i++) begin
      if (is_volt ? volt_req : freq_req) break;
      step();
    end
    check(name, is_volt ? volt_req : freq_req, 1);
  endtask

  // Full up-step from level lvl with acks returned two cycles after each request.
  task automatic hs_up(input int lvl);
    wait_req(1'b1, "up_vreq");
    check("up_vlevel", volt_level, lvl + 1);
    check("up_freq_idle", freq_req, 0);
    step(); step();
    volt_ack = 1'b1; step(); volt_ack = 1'b0;
    check("up_vreq_drop", volt_req, 0);
    check("up_freq_req", freq_req, 1);
    check("up_flevel", freq_level, lvl + 1);
    check("up_op_hold", op_level, lvl);
    step(); step();
    freq_ack = 1'b1; step(); freq_ack = 1'b0;
    check("up_op_new", op_level, lvl + 1);
    check("up_busy_done", busy, 0);
    check("up_freq_drop", freq_req, 0);
  endtask

  task automatic hs_down(input int lvl);
    wait_req(1'b0, "dn_freq_req");
    check("dn_flevel", freq_level, lvl - 1);
    check("dn_volt_idle", volt_req, 0);
    step(); step();
    freq_ack = 1'b1; step(); freq_ack = 1'b0;
    check("dn_freq_drop", freq_req, 0);
    check("dn_vreq", volt_req, 1);
    check("dn_vlevel", volt_level, lvl - 1);
    check("dn_op_hold", op_level, lvl);
    step(); step();
    volt_ack = 1'b1; step(); volt_ack = 1'b0;
    check("dn_op_new", op_level, lvl - 1);
    check("dn_busy_done", busy, 0);
    check("dn_vreq_drop", volt_req, 0);
  endtask

  task automatic no_req_samples(input int u, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      sample(u);
      check(name, {30'd0, volt_req, freq_req}, 0);
    end
  endtask

  initial begin
    vecs = '{
      '{90, 0, 0}, '{50, 0, 0}, '{90, 0, 0}, '{90, 0, 0},
      '{0, 0, 0},  '{0, 0, 0},  '{0, 0, 0},  '{0, 0, 0},
      '{0, 0, 0},  '{90, 0, 0}, '{90, 0, 0}, '{250, 1, 1}
    };

    step(); step();
    rst = 1'b0;
    check("rst_op", op_level, 0);
    check("rst_vreq", volt_req, 0);
    check("rst_freq", freq_req, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_vlevel", volt_level, 0);
    check("rst_flevel", freq_level, 0);

    // Voting from level 0: interruptions clear the count, 250 saturates to an up vote.
    for (int i = 0; i < 12; i++) begin
      sample(vecs[i].u);
      check($sformatf("vec%0d_vreq", i), volt_req, vecs[i].exp_vreq);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_freq", i), freq_req, 0);
    end
    hs_up(0);
    check("up1_terr", timeout_err, 0);

    // Samples during a step are ignored; both acks together in V_UP advance only one state.
    sample(95); sample(95); sample(95);
    check("busy_trig", volt_req, 1);
    sample(95); sample(95);
    volt_ack = 1'b1; freq_ack = 1'b1; step(); volt_ack = 1'b0; freq_ack = 1'b0;
    check("both_ack_freq", freq_req, 1);
    check("both_ack_op", op_level, 1);
    sample(95);
    freq_ack = 1'b1; step(); freq_ack = 1'b0;
    check("busy_step_op", op_level, 2);
    check("busy_step_idle", busy, 0);
    no_req_samples(95, 2, "post_busy_no_req");
    sample(95);
    check("post_busy_trig", volt_req, 1);
    hs_up(2);

    // Stray acks in IDLE, then saturation at the top level.
    volt_ack = 1'b1; freq_ack = 1'b1; step(); volt_ack = 1'b0; freq_ack = 1'b0;
    check("stray_ack_busy", busy, 0);
    no_req_samples(100, 5, "max_no_req");
    no_req_samples(250, 1, "max_sat_no_req");
    check("max_op", op_level, 3);

    // Down-steps: frequency first, then voltage.
    sample(10); sample(10); sample(10);
    hs_down(3);
    sample(10); sample(10); sample(50); sample(10); sample(10);
    check("dn_cleared_freq", freq_req, 0);
    check("dn_cleared_busy", busy, 0);
    sample(10);
    hs_down(2);
    sample(10); sample(10); sample(10);
    hs_down(1);
    no_req_samples(0, 5, "min_no_req");
    check("min_op", op_level, 0);

    // Voltage ack never arrives: request held 255 cycles, then abort.
    sample(90); sample(90); sample(90);
    begin
      int cnt = 0;
      for (int i = 0; i < 400; i++) begin
        if (!volt_req) break;
        cnt++;
        step();
      end
      check("to_cycles", cnt, 255);
    end
    check("to_terr", timeout_err, 1);
    check("to_op", op_level, 0);
    check("to_busy", busy, 0);
    check("to_vlevel_kept", volt_level, 1);
    no_req_samples(50, 2, "to_sticky_no_req");
    check("to_sticky", timeout_err, 1);
    sample(90); sample(90); sample(90);
    hs_up(0);
    check("to_sticky_after_step", timeout_err, 1);

    // Reset in the middle of F_UP drops the request with no ack.
    sample(90); sample(90); sample(90);
    wait_req(1'b1, "rst_seq_vreq");
    volt_ack = 1'b1; step(); volt_ack = 1'b0;
    check("rst_seq_freq", freq_req, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mid_freq", freq_req, 0);
    check("rst_mid_op", op_level, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_terr", timeout_err, 0);

`ifdef DVFS_GOV_OVERRIDE_EN
    force_level = 2'd3;
    force_en    = 1'b1;
    hs_up(0);
    hs_up(1);
    hs_up(2);
    force_en = 1'b0;
    step();
    check("force_op", op_level, 3);
    check("force_busy", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
